// File: rtl/page_table_walker.sv
// page_table_walker: Sv32 two-level hardware page-table walker that refills a round-robin TLB slot.
module page_table_walker #(
    parameter int TLB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        walk_start,
    input  logic [31:0] walk_vaddr,
    input  logic [31:0] satp,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] tlb_vpn_out,
    output logic [31:0] tlb_ppn_perms_out,
    output logic [31:0] tlb_write_index,
    output logic        busy,
    output logic        walk_done,
    output logic        walk_fault
);
    typedef enum logic [2:0] {IDLE, L1, L0, FILL, FAULT} state_t;
    state_t      state, state_n;
    logic [19:0] vpn, vpn_n;
    logic [31:0] addr_n, entry_n;
    logic [3:0]  rr_ptr;
    logic        leaf, bad, unused_ok;
    assign unused_ok = ^{satp[30:20], walk_vaddr[11:0]};
    assign leaf = mem_rdata[1] | mem_rdata[3];
    assign bad  = !mem_rdata[0] || (!mem_rdata[1] && mem_rdata[2]);
    always_comb begin
        state_n = state;
        vpn_n   = vpn;
        addr_n  = mem_addr;
        entry_n = mem_rdata;
        unique case (state)
            IDLE: if (walk_start) begin
                vpn_n   = walk_vaddr[31:12];
                addr_n  = {satp[19:0], walk_vaddr[31:22], 2'b00};
                state_n = satp[31] ? L1 : FAULT;
            end
            L1: if (mem_ack) begin
                state_n = (bad || (leaf && |mem_rdata[19:10])) ? FAULT : leaf ? FILL : L0;
                addr_n  = {mem_rdata[29:10], vpn[9:0], 2'b00};
                entry_n = {mem_rdata[31:20], vpn[9:0], mem_rdata[9:0]};
            end
            L0: if (mem_ack) state_n = (bad || !leaf) ? FAULT : FILL;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            vpn               <= '0;
            rr_ptr            <= '0;
            mem_req           <= 1'b0;
            mem_addr          <= '0;
            busy              <= 1'b0;
            walk_done         <= 1'b0;
            walk_fault        <= 1'b0;
            tlb_write_index   <= '0;
            tlb_vpn_out       <= '0;
            tlb_ppn_perms_out <= '0;
        end else begin
            vpn               <= vpn_n;
            rr_ptr            <= (state != FILL) ? rr_ptr : (rr_ptr == 4'(TLB_ENTRIES - 1)) ? 4'd0 : rr_ptr + 4'd1;
            mem_req           <= state_n inside {L1, L0};
            mem_addr          <= (state_n inside {L1, L0}) ? addr_n : '0;
            busy              <= state_n != IDLE;
            walk_done         <= state_n inside {FILL, FAULT};
            walk_fault        <= state_n == FAULT;
            tlb_write_index   <= (state_n == FILL) ? {27'b0, 1'b1, rr_ptr} : '0;
            tlb_vpn_out       <= (state_n == FILL) ? {12'b0, vpn_n} : '0;
            tlb_ppn_perms_out <= (state_n == FILL) ? entry_n : '0;
        end
    end
endmodule
